// File: rtl/dm_ctrl_pkg.sv
// dm_ctrl_pkg: sequencer states, funct3 codes and the access alignment rule
package dm_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dm_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic misaligned(input logic [2:0] func, input logic [1:0] lo);
    return (func == F3_B || func == F3_BU) ? 1'b0 : (func == F3_H || func == F3_HU) ? lo[0] : |lo;
  endfunction
endpackage

// File: rtl/dm_store_align.sv
// dm_store_align: maps funct3 and address low bits to byte strobes, lane-replicated data and misalignment
module dm_store_align
  import dm_ctrl_pkg::*;
(
  input  logic [2:0]  func,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic        misalign
);
  logic is_b;
  logic is_h;
  always_comb begin
    is_b = func == F3_B || func == F3_BU;
    is_h = func == F3_H || func == F3_HU;
    wstrb = is_b ? 4'b0001 << addr_lo : is_h ? 4'b0011 << addr_lo : 4'b1111;
    wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    misalign = misaligned(func, addr_lo);
  end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequences one MEM-stage load/store onto the data-memory request/response channel and stalls the pipeline
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_func_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        stall_o,
  output logic        ld_valid_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        dm_req_valid_o,
  input  logic        dm_req_ready_i,
  output logic [31:0] dm_addr_o,
  output logic        dm_we_o,
  output logic [3:0]  dm_wstrb_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i,
  input  logic        dm_bvalid_i
);
  dm_state_t   state;
  dm_state_t   state_n;
  logic [7:0]  cnt;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c;
  logic        mis_c;
  logic        take;
  logic        resp;
  logic        expire;
  dm_store_align u_align (
    .func      (mem_func_i),
    .addr_lo   (mem_addr_i[1:0]),
    .wdata     (mem_wdata_i),
    .wstrb     (strb_c),
    .wdata_rep (wdata_c),
    .misalign  (mis_c)
  );
  always_comb begin
    take = state == IDLE && mem_req_valid_i && !mis_c;
    resp = state == WAIT && (dm_we_o ? dm_bvalid_i : dm_rvalid_i);
    expire = state == WAIT && !resp && cnt == 8'(TIMEOUT_CYCLES - 1);
    state_n = take ? REQ
            : (state == REQ && dm_req_ready_i) ? WAIT
            : (resp || expire) ? DONE
            : state == DONE ? IDLE
            : state;
    stall_o = take || state == REQ || state == WAIT;
    misalign_o = state == IDLE && mem_req_valid_i && mis_c;
    dm_req_valid_o = state == REQ;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      ld_valid_o <= 1'b0;
      err_o      <= 1'b0;
      ld_data_o  <= 32'd0;
      dm_addr_o  <= 32'd0;
      dm_we_o    <= 1'b0;
      dm_wstrb_o <= 4'd0;
      dm_wdata_o <= 32'd0;
    end else begin
      state      <= state_n;
      cnt        <= state == WAIT ? cnt + 8'd1 : 8'd0;
      ld_valid_o <= resp && !dm_we_o;
      err_o      <= expire;
      if (resp && !dm_we_o) ld_data_o <= dm_rdata_i;
      if (take) begin
        dm_addr_o  <= {mem_addr_i[31:2], 2'b00};
        dm_we_o    <= mem_we_i;
        dm_wstrb_o <= mem_we_i ? strb_c : 4'd0;
        dm_wdata_o <= mem_we_i ? wdata_c : 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed transactions checked every cycle against a transaction-level model
module tb_dm_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [2:0]  mem_func_i = 3'b0;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] mem_wdata_i = 32'd0;
  logic        stall_o;
  logic        ld_valid_o;
  logic [31:0] ld_data_o;
  logic        misalign_o;
  logic        err_o;
  logic        dm_req_valid_o;
  logic        dm_req_ready_i = 1'b0;
  logic [31:0] dm_addr_o;
  logic        dm_we_o;
  logic [3:0]  dm_wstrb_o;
  logic [31:0] dm_wdata_o;
  logic        dm_rvalid_i = 1'b0;
  logic [31:0] dm_rdata_i = 32'd0;
  logic        dm_bvalid_i = 1'b0;
  int vec = 0;
  int miss = 0;
  int stalls = 0;
  int ldvs = 0;
  int errs = 0;
  int mises = 0;
  int reqs = 0;
  logic        en = 1'b0;
  logic        e_stall = 1'b0;
  logic        e_mis = 1'b0;
  logic        e_req = 1'b0;
  logic        e_ldv = 1'b0;
  logic        e_err = 1'b0;
  logic        e_we = 1'b0;
  logic [31:0] e_ld = 32'd0;
  logic [31:0] e_addr = 32'd0;
  logic [31:0] e_wdata = 32'd0;
  logic [3:0]  e_strb = 4'd0;
  logic [31:0] seen_addr = 32'd0;
  logic [31:0] seen_wdata = 32'd0;
  logic [3:0]  seen_strb = 4'd0;
  always #5 clk = ~clk;
  dm_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_valid_i (mem_req_valid_i),
    .mem_we_i        (mem_we_i),
    .mem_func_i      (mem_func_i),
    .mem_addr_i      (mem_addr_i),
    .mem_wdata_i     (mem_wdata_i),
    .stall_o         (stall_o),
    .ld_valid_o      (ld_valid_o),
    .ld_data_o       (ld_data_o),
    .misalign_o      (misalign_o),
    .err_o           (err_o),
    .dm_req_valid_o  (dm_req_valid_o),
    .dm_req_ready_i  (dm_req_ready_i),
    .dm_addr_o       (dm_addr_o),
    .dm_we_o         (dm_we_o),
    .dm_wstrb_o      (dm_wstrb_o),
    .dm_wdata_o      (dm_wdata_o),
    .dm_rvalid_i     (dm_rvalid_i),
    .dm_rdata_i      (dm_rdata_i),
    .dm_bvalid_i     (dm_bvalid_i)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, want %h", n, act, exp);
    end
  endtask
  function automatic int sz(input logic [2:0] f);
    return (f == 3'b000 || f == 3'b100) ? 1 : (f == 3'b001 || f == 3'b101) ? 2 : 4;
  endfunction
  always @(negedge clk) begin
    if (en) begin
      chk("stall", 32'(stall_o), 32'(e_stall));
      chk("misalign", 32'(misalign_o), 32'(e_mis));
      chk("req_valid", 32'(dm_req_valid_o), 32'(e_req));
      chk("ld_valid", 32'(ld_valid_o), 32'(e_ldv));
      chk("err", 32'(err_o), 32'(e_err));
      chk("ld_data", ld_data_o, e_ld);
      if (e_req) begin
        chk("addr", dm_addr_o, e_addr);
        chk("we", 32'(dm_we_o), 32'(e_we));
        chk("wstrb", 32'(dm_wstrb_o), 32'(e_strb));
        if (e_we) chk("wdata", dm_wdata_o, e_wdata);
      end
      if (stall_o) stalls++;
      if (ld_valid_o) ldvs++;
      if (err_o) errs++;
      if (misalign_o) mises++;
      if (dm_req_valid_o) begin
        reqs++;
        seen_addr = dm_addr_o;
        seen_strb = dm_wstrb_o;
        seen_wdata = dm_wdata_o;
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int r, input int d, input bit to);
    int s;
    bit mis;
    s = sz(f);
    mis = (int'(a[1:0]) % s) != 0;
    stalls = 0; ldvs = 0; errs = 0; mises = 0; reqs = 0;
    mem_req_valid_i = 1'b1; mem_we_i = we; mem_func_i = f; mem_addr_i = a; mem_wdata_i = wd;
    e_stall = !mis; e_mis = mis; e_ldv = 1'b0; e_err = 1'b0;
    cyc();
    e_mis = 1'b0;
    if (!mis) begin
      e_req = 1'b1; e_we = we; e_addr = a & ~32'h3;
      e_strb = we ? 4'(((1 << s) - 1) << a[1:0]) : 4'h0;
      e_wdata = s == 1 ? 32'(wd[7:0]) * 32'h01010101 : s == 2 ? 32'(wd[15:0]) * 32'h00010001 : wd;
      for (int i = 0; i < r; i++) begin
        dm_rvalid_i = 1'b1; dm_bvalid_i = 1'b1; dm_rdata_i = 32'hBAD00000 + 32'(i);
        cyc();
      end
      dm_req_ready_i = 1'b1;
      cyc();
      dm_req_ready_i = 1'b0; e_req = 1'b0;
      for (int i = 0; i < (to ? 8 : d); i++) begin
        dm_rvalid_i = we; dm_bvalid_i = !we; dm_rdata_i = 32'hBAD10000 + 32'(i);
        cyc();
      end
      if (!to) begin
        dm_rvalid_i = !we; dm_bvalid_i = we; dm_rdata_i = rd;
        cyc();
      end
      dm_rvalid_i = 1'b0; dm_bvalid_i = 1'b0;
      e_stall = 1'b0; e_ldv = !we && !to; e_err = to;
      if (e_ldv) e_ld = rd;
      cyc();
    end
    mem_req_valid_i = 1'b0; e_stall = 1'b0; e_ldv = 1'b0; e_err = 1'b0;
    dm_rvalid_i = 1'b1; dm_rdata_i = 32'hBAD20000;
    cyc();
    dm_rvalid_i = 1'b0;
  endtask
  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    en = 1'b1;
    chk("reset_addr", dm_addr_o, 32'd0);
    chk("reset_wstrb", 32'(dm_wstrb_o), 32'd0);
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
    chk("lw_stalls", 32'(stalls), 32'd3);
    chk("lw_ld_pulses", 32'(ldvs), 32'd1);
    chk("lw_data", ld_data_o, 32'hDEADBEEF);
    chk("lw_addr", seen_addr, 32'h100);
    chk("lw_strb", 32'(seen_strb), 32'h0);
    run_op(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0, 0, 1'b0);
    chk("sb_strb", 32'(seen_strb), 32'h8);
    chk("sb_wdata", seen_wdata, 32'hA5A5A5A5);
    chk("sb_addr", seen_addr, 32'h200);
    chk("sb_ld_pulses", 32'(ldvs), 32'd0);
    chk("sb_stalls", 32'(stalls), 32'd3);
    run_op(1'b0, 3'b001, 32'h301, 32'h0, 32'h0, 0, 0, 1'b0);
    chk("sh_mis_pulses", 32'(mises), 32'd1);
    chk("sh_mis_reqs", 32'(reqs), 32'd0);
    chk("sh_mis_stalls", 32'(stalls), 32'd0);
    run_op(1'b0, 3'b010, 32'h302, 32'h0, 32'h0, 0, 0, 1'b0);
    chk("lw_mis_pulses", 32'(mises), 32'd1);
    chk("lw_mis_reqs", 32'(reqs), 32'd0);
    run_op(1'b0, 3'b001, 32'h402, 32'h0, 32'h13579BDF, 4, 3, 1'b0);
    chk("lh_stalls", 32'(stalls), 32'd10);
    chk("lh_reqs", 32'(reqs), 32'd5);
    chk("lh_data", ld_data_o, 32'h13579BDF);
    run_op(1'b1, 3'b001, 32'h502, 32'h1234BEEF, 32'h0, 1, 2, 1'b0);
    chk("sh_strb", 32'(seen_strb), 32'hC);
    chk("sh_wdata", seen_wdata, 32'hBEEFBEEF);
    run_op(1'b1, 3'b010, 32'h600, 32'hCAFEF00D, 32'h0, 0, 1, 1'b0);
    run_op(1'b0, 3'b100, 32'h601, 32'h0, 32'h0BADF00D, 2, 1, 1'b0);
    run_op(1'b1, 3'b011, 32'h704, 32'h01020304, 32'h0, 0, 0, 1'b0);
    chk("f011_strb", 32'(seen_strb), 32'hF);
    run_op(1'b0, 3'b110, 32'h702, 32'h0, 32'h0, 0, 0, 1'b0);
    chk("f110_mis", 32'(mises), 32'd1);
    run_op(1'b0, 3'b101, 32'h706, 32'h0, 32'h2468ACE0, 1, 0, 1'b0);
    run_op(1'b0, 3'b010, 32'h900, 32'h0, 32'h0, 0, 0, 1'b1);
    chk("to_err_pulses", 32'(errs), 32'd1);
    chk("to_ld_pulses", 32'(ldvs), 32'd0);
    chk("to_stalls", 32'(stalls), 32'd10);
    chk("to_data_held", ld_data_o, 32'h2468ACE0);
    stalls = 0;
    mem_req_valid_i = 1'b1; mem_we_i = 1'b0; mem_func_i = 3'b010; mem_addr_i = 32'hA00;
    e_stall = 1'b1;
    cyc();
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'hA00; e_strb = 4'h0; dm_req_ready_i = 1'b1;
    cyc();
    dm_req_ready_i = 1'b0; e_req = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; mem_req_valid_i = 1'b0; e_stall = 1'b0; e_ld = 32'd0;
    cyc();
    chk("rst_stalls", 32'(stalls), 32'd3);
    chk("rst_addr", dm_addr_o, 32'd0);
    chk("rst_data", ld_data_o, 32'd0);
    run_op(1'b0, 3'b010, 32'hA04, 32'h0, 32'h55AA55AA, 0, 0, 1'b0);
    chk("post_rst_data", ld_data_o, 32'h55AA55AA);
    chk("post_rst_stalls", 32'(stalls), 32'd3);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
